// File: rtl/nx_ram_arbiter.sv
// Round-robin two-requester arbiter and power-up clear sequencer
// for one NX_RAM port, with read data steered back to its issuer.
module nx_ram_arbiter #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 24,
  parameter int READ_LATENCY = 1,
  parameter int CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                  clock,
  input  logic                  async_reset,
  input  logic                  rq0_valid,
  output logic                  rq0_ready,
  input  logic                  rq0_we,
  input  logic [ADDR_WIDTH-1:0] rq0_addr,
  input  logic [DATA_WIDTH-1:0] rq0_wdata,
  input  logic                  rq1_valid,
  output logic                  rq1_ready,
  input  logic                  rq1_we,
  input  logic [ADDR_WIDTH-1:0] rq1_addr,
  input  logic [DATA_WIDTH-1:0] rq1_wdata,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  init_done
);

  typedef enum logic {CLEAR, ARB} state_t;

  localparam state_t INIT_STATE =
    (CLEAR_ON_RESET != 0) ? CLEAR : ARB;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_t state, state_nx;
  logic [ADDR_WIDTH-1:0] clr_cnt, clr_cnt_nx;
  logic last, last_nx;
  logic gnt0, gnt1, acc0, acc1;
  logic cs_nx, we_nx;
  logic [ADDR_WIDTH-1:0] addr_nx;
  logic [DATA_WIDTH-1:0] wdata_nx;
  logic push_v, push_id;
  logic [READ_LATENCY:0] tag_v, tag_id;

  // last=1 means requester 1 was served most recently
  assign gnt0 = rq0_valid & (~rq1_valid | last);
  assign gnt1 = rq1_valid & (~rq0_valid | ~last);

  assign rq0_ready = (state == ARB) & ~async_reset & gnt0;
  assign rq1_ready = (state == ARB) & ~async_reset & gnt1;
  assign acc0 = rq0_valid & rq0_ready;
  assign acc1 = rq1_valid & rq1_ready;

  assign init_done = (state == ARB);

  assign rsp0_valid = tag_v[READ_LATENCY] & ~tag_id[READ_LATENCY];
  assign rsp1_valid = tag_v[READ_LATENCY] & tag_id[READ_LATENCY];
  assign rsp0_rdata = ram_rdata;
  assign rsp1_rdata = ram_rdata;

  always_comb begin
    state_nx   = state;
    clr_cnt_nx = clr_cnt;
    last_nx    = last;
    cs_nx      = 1'b0;
    we_nx      = 1'b0;
    addr_nx    = ram_addr;
    wdata_nx   = ram_wdata;
    push_v     = 1'b0;
    push_id    = 1'b0;
    unique case (state)
      CLEAR: begin
        cs_nx    = 1'b1;
        we_nx    = 1'b1;
        addr_nx  = clr_cnt;
        wdata_nx = CLEAR_VALUE;
        if (clr_cnt == LAST_ADDR) begin
          state_nx = ARB;
        end else begin
          clr_cnt_nx = clr_cnt + ADDR_WIDTH'(1);
        end
      end
      ARB: begin
        unique case (1'b1)
          acc0: begin
            cs_nx    = 1'b1;
            we_nx    = rq0_we;
            addr_nx  = rq0_addr;
            wdata_nx = rq0_wdata;
            last_nx  = 1'b0;
            push_v   = ~rq0_we;
            push_id  = 1'b0;
          end
          acc1: begin
            cs_nx    = 1'b1;
            we_nx    = rq1_we;
            addr_nx  = rq1_addr;
            wdata_nx = rq1_wdata;
            last_nx  = 1'b1;
            push_v   = ~rq1_we;
            push_id  = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge async_reset) begin
    if (async_reset) begin
      state     <= INIT_STATE;
      clr_cnt   <= '0;
      last      <= 1'b1;
      ram_cs    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      tag_v     <= '0;
      tag_id    <= '0;
    end else begin
      state     <= state_nx;
      clr_cnt   <= clr_cnt_nx;
      last      <= last_nx;
      ram_cs    <= cs_nx;
      ram_we    <= we_nx;
      ram_addr  <= addr_nx;
      ram_wdata <= wdata_nx;
      // stage 0 lines up with the command register, the rest with RAM latency
      tag_v     <= {tag_v[READ_LATENCY-1:0], push_v};
      tag_id    <= {tag_id[READ_LATENCY-1:0], push_id};
    end
  end

endmodule
